fetch_stage: RTL and testbench

//  Instruction-fetch front end. Owns the PC, drives the instruction-memory address and captures
//  the combinational read word. Buffers fetched words in a small queue, then hands them to

---
 rtl/rv32i_pkg.sv | 34 +++
 rtl/fetch_stage_if.sv | 42 ++++
 rtl/fetch_queue.sv | 65 ++++++
 rtl/fetch_stage.sv | 102 ++++++++++
 tb/tb_fetch_stage.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/rv32i_pkg.sv
// Shared fetch-stage types: fault codes, queue entry layout, FSM states.
// Also holds the fetch-address classifier used when pushing entries.
package rv32i_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FAULT_NONE     = 2'b00,
        FAULT_MISALIGN = 2'b01,
        FAULT_RANGE    = 2'b10
    } fetch_fault_t;

    typedef struct packed {
        logic [31:0]  instr;
        logic [31:0]  pc;
        fetch_fault_t fault;
    } fetch_entry_t;

    typedef enum logic {
        ST_RUN,
        ST_HALTED
    } fetch_state_t;

    // Misalignment wins over range; range compare is unsigned.
    function automatic fetch_fault_t classify(
        input logic [31:0] pc,
        input logic [31:0] last_pc
    );
        if (pc[1:0] != 2'b00) return FAULT_MISALIGN;
        if (pc > last_pc) return FAULT_RANGE;
        return FAULT_NONE;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: imem port, redirect input and decode handshake.
// master = fetch stage side, slave = memory/decode/branch side.
interface fetch_stage_if;

    logic [31:0] ImemAddress;
    logic [31:0] ImemInstruction;
    logic        Redirect;
    logic [31:0] RedirectPC;
    logic        IfValid;
    logic        IdReady;
    logic [31:0] IfInstruction;
    logic [31:0] IfPC;
    logic [31:0] IfPCPlus4;
    logic [1:0]  IfFault;

    modport master (
        output ImemAddress,
        input  ImemInstruction,
        input  Redirect,
        input  RedirectPC,
        output IfValid,
        input  IdReady,
        output IfInstruction,
        output IfPC,
        output IfPCPlus4,
        output IfFault
    );

    modport slave (
        input  ImemAddress,
        output ImemInstruction,
        output Redirect,
        output RedirectPC,
        input  IfValid,
        output IdReady,
        input  IfInstruction,
        input  IfPC,
        input  IfPCPlus4,
        input  IfFault
    );

endinterface

// File: rtl/fetch_queue.sv
// Circular FIFO of fetch entries with flush; storage resets to zero.
// Flush keeps the read pointer so the head word holds its last value.
import rv32i_pkg::*;

module fetch_queue #(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wdata,
    output fetch_entry_t rdata,
    output logic         full,
    output logic         empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH-1)) ? '0 : p + AW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; flush empties in one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= rd_ptr;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= inc(wr_ptr);
            if (do_pop)  rd_ptr <= inc(rd_ptr);
            if (do_push && !do_pop) count <= count + CW'(1);
            if (!do_push && do_pop) count <= count - CW'(1);
        end
    end

    // Entry storage, cleared on reset so head outputs read zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns FetchPC, RUN/HALTED control, fault tagging
// and the push/pop control of the fetch queue feeding decode.
import rv32i_pkg::*;

module fetch_stage #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES  = 1024,
    parameter int          QUEUE_DEPTH = 2
) (
    input logic           Clk,
    input logic           Rst_n,
    fetch_stage_if.master bus
);

    localparam logic [31:0] LAST_PC = 32'(IMEM_BYTES - 4);
    localparam int          CW      = $clog2(QUEUE_DEPTH+1);

    fetch_state_t state;
    fetch_state_t state_nx;
    logic [31:0]  fetch_pc;
    logic [31:0]  fetch_pc_nx;
    fetch_fault_t fault;
    fetch_entry_t wentry;
    fetch_entry_t head;
    logic         push;
    logic         pop;
    logic         seen;
    logic         q_full;
    logic         q_empty;
    logic [CW-1:0] q_count;

    assign fault  = classify(fetch_pc, LAST_PC);
    assign wentry = '{
        instr: (fault == FAULT_NONE) ? bus.ImemInstruction : NOP_INSTR,
        pc:    fetch_pc,
        fault: fault
    };
    assign pop    = bus.IdReady & ~q_empty;

    // Next state, next PC and push decision; redirect overrides all.
    always_comb begin
        state_nx    = state;
        fetch_pc_nx = fetch_pc;
        push        = 1'b0;
        if (bus.Redirect) begin
            state_nx    = ST_RUN;
            fetch_pc_nx = bus.RedirectPC;
        end else begin
            unique case (state)
                ST_RUN: begin
                    if (~q_full | pop) begin
                        push = 1'b1;
                        if (fault == FAULT_NONE) begin
                            fetch_pc_nx = fetch_pc + 32'd4;
                        end else begin
                            state_nx = ST_HALTED;
                        end
                    end
                end
                ST_HALTED: begin
                    state_nx = ST_HALTED;
                end
            endcase
        end
    end

    // State, PC and the "anything pushed yet" flag for IfPCPlus4.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state    <= ST_RUN;
            fetch_pc <= RESET_PC;
            seen     <= 1'b0;
        end else begin
            state    <= state_nx;
            fetch_pc <= fetch_pc_nx;
            if (push) seen <= 1'b1;
        end
    end

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk   (Clk),
        .rst_n (Rst_n),
        .push  (push),
        .pop   (pop),
        .flush (bus.Redirect),
        .wdata (wentry),
        .rdata (head),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

    assign bus.ImemAddress   = fetch_pc;
    assign bus.IfValid       = (q_count != '0);
    assign bus.IfInstruction = head.instr;
    assign bus.IfPC          = head.pc;
    assign bus.IfPCPlus4     = seen ? head.pc + 32'd4 : 32'd0;
    assign bus.IfFault       = head.fault;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed + random bench for fetch_stage against a queue-level
// reference model of fetch order, faults, halting and redirects.
module tb_fetch_stage;

    localparam int          QD      = 2;
    localparam logic [31:0] LASTPC  = 32'h0000_03FC;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [1:0]  fault;
    } ref_t;

    logic Clk;
    logic Rst_n;
    int   n_assert;
    int   n_fail;

    ref_t        mq[$];
    logic [31:0] mpc;
    bit          halted;

    fetch_stage_if bus();

    fetch_stage #(
        .RESET_PC    (32'h0),
        .IMEM_BYTES  (1024),
        .QUEUE_DEPTH (QD)
    ) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return 32'hA500_0000 + a;
    endfunction

    assign bus.ImemInstruction = imem_word(bus.ImemAddress);

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_head();
        chk("if_valid", 32'(bus.IfValid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("if_pc", bus.IfPC, mq[0].pc);
            chk("if_instr", bus.IfInstruction, mq[0].instr);
            chk("if_fault", 32'(bus.IfFault), 32'(mq[0].fault));
            chk("if_pc4", bus.IfPCPlus4, mq[0].pc + 32'd4);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mpc    = 32'h0;
        halted = 1'b0;
    endtask

    // One clock: apply inputs, advance model, check after the edge.
    task automatic cyc(input logic rdy, input logic rd,
                       input logic [31:0] rpc);
        ref_t e;
        bus.IdReady    = rdy;
        bus.Redirect   = rd;
        bus.RedirectPC = rpc;
        #1;
        chk("imem_addr", bus.ImemAddress, mpc);
        if (mq.size() != 0 && rdy) void'(mq.pop_front());
        if (rd) begin
            mq.delete();
            mpc    = rpc;
            halted = 1'b0;
        end else if (!halted && mq.size() < QD) begin
            e.pc = mpc;
            if (mpc % 4 != 0) e.fault = 2'b01;
            else if (mpc > LASTPC) e.fault = 2'b10;
            else e.fault = 2'b00;
            e.instr = (e.fault == 2'b00) ? imem_word(mpc) : 32'h13;
            mq.push_back(e);
            if (e.fault == 2'b00) mpc = mpc + 32'd4;
            else halted = 1'b1;
        end
        @(posedge Clk);
        @(negedge Clk);
        chk_head();
    endtask

    initial begin
        logic [31:0] tgt;
        n_assert = 0;
        n_fail   = 0;
        Rst_n          = 1'b0;
        bus.IdReady    = 1'b0;
        bus.Redirect   = 1'b0;
        bus.RedirectPC = 32'h0;
        model_reset();
        repeat (2) @(negedge Clk);
        chk("rst_valid", 32'(bus.IfValid), 32'h0);
        chk("rst_pc", bus.IfPC, 32'h0);
        chk("rst_pc4", bus.IfPCPlus4, 32'h0);
        chk("rst_instr", bus.IfInstruction, 32'h0);
        chk("rst_fault", 32'(bus.IfFault), 32'h0);
        chk("rst_addr", bus.ImemAddress, 32'h0);
        Rst_n = 1'b1;

        // streaming ramp with decode always ready
        repeat (8) cyc(1'b1, 1'b0, 32'h0);

        // back-pressure from a fresh start
        Rst_n = 1'b0;
        model_reset();
        @(negedge Clk);
        Rst_n = 1'b1;
        repeat (5) cyc(1'b0, 1'b0, 32'h0);
        chk("stall_addr", bus.ImemAddress, 32'h8);
        chk("stall_pc", bus.IfPC, 32'h0);
        repeat (4) cyc(1'b1, 1'b0, 32'h0);

        // redirect while full and popping
        repeat (3) cyc(1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, 32'h40);
        chk("redir_valid", 32'(bus.IfValid), 32'h0);
        cyc(1'b1, 1'b0, 32'h0);
        chk("redir_pc", bus.IfPC, 32'h40);

        // misaligned redirect target
        cyc(1'b0, 1'b1, 32'h42);
        cyc(1'b0, 1'b0, 32'h0);
        chk("mis_fault", 32'(bus.IfFault), 32'h1);
        chk("mis_instr", bus.IfInstruction, 32'h13);
        repeat (4) cyc(1'b1, 1'b0, 32'h0);
        chk("mis_hold", bus.ImemAddress, 32'h42);

        // run off the end of memory
        cyc(1'b1, 1'b1, 32'h3F4);
        repeat (3) cyc(1'b1, 1'b0, 32'h0);
        chk("end_last", bus.IfPC, 32'h3FC);
        chk("end_last_f", 32'(bus.IfFault), 32'h0);
        cyc(1'b1, 1'b0, 32'h0);
        chk("range_pc", bus.IfPC, 32'h400);
        chk("range_fault", 32'(bus.IfFault), 32'h2);
        repeat (3) cyc(1'b1, 1'b0, 32'h0);
        chk("halt_addr", bus.ImemAddress, 32'h400);

        // wrap-around target near 2^32
        cyc(1'b1, 1'b1, 32'hFFFF_FFFC);
        cyc(1'b0, 1'b0, 32'h0);
        chk("wrap_pc4", bus.IfPCPlus4, 32'h0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            tgt = 32'h0;
            case ($urandom_range(0, 4))
                0: tgt = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
                1: tgt = {22'h0, 8'($urandom_range(0, 255)), 2'b10};
                2: tgt = 32'h3F8;
                3: tgt = 32'hFFFF_FFFC;
                default: tgt = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            endcase
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0, tgt);
        end

        // asynchronous reset between edges
        cyc(1'b1, 1'b1, 32'h100);
        repeat (3) cyc(1'b0, 1'b0, 32'h0);
        #2;
        Rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.IfValid), 32'h0);
        chk("arst_addr", bus.ImemAddress, 32'h0);
        model_reset();
        @(posedge Clk);
        @(negedge Clk);
        Rst_n = 1'b1;
        repeat (6) cyc(1'b1, 1'b0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
